pipe_in_arbiter: RTL and testbench

Round-robin arbiter that shares one outbound `PipeIn` port between `N` method-to-pipe marshallers. Each marshaller delivers a complete, pre-formatted message in a single `enq` beat. Each requester has a one-entry holding register, so its `RDY` never depends on any `ENA`. The arbiter drains the holding registers onto the shared pipe, one message per cycle, in round-robin order. It sits between the per-interface marshallers and the single host-bound pipe.

---
 rtl/pipe_in_arbiter.sv | 120 ++++++++++++
 tb/tb_pipe_in_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_in_arbiter.sv
// -----------------------------------------------------------------------------
// pipe_in_arbiter
//
// Shares one outbound PipeIn port between N method-to-pipe marshallers.
// Each requester owns a one-entry holding register. Its ready is therefore
// a function of that register and the pipe ready only, and never of any
// enqueue strobe. Valid holding registers are drained onto the pipe, one
// message per cycle, in round-robin order. Messages pass through bit-exact.
//
// Parameters
//   N      number of requesters (2..8)
//   WIDTH  message width in bits (one full pipe beat)
//
// Ports
//   CLK            clock
//   nRST           synchronous active-low reset
//   req_enq__ENA   [N]        per-requester enqueue strobe
//   req_enq_v      [N*WIDTH]  per-requester message, requester i at [i*WIDTH +: WIDTH]
//   req_enq__RDY   [N]        per-requester ready
//   pipe_enq__ENA             shared pipe enqueue strobe
//   pipe_enq_v     [WIDTH]    shared pipe message
//   pipe_enq__RDY             shared pipe ready
//   msg_count      [32]       messages forwarded since reset (wraps)
//   busy                      any holding register valid
// -----------------------------------------------------------------------------
module pipe_in_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 144
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [N-1:0]         req_enq__ENA,
    input  logic [N*WIDTH-1:0]   req_enq_v,
    output logic [N-1:0]         req_enq__RDY,
    output logic                 pipe_enq__ENA,
    output logic [WIDTH-1:0]     pipe_enq_v,
    input  logic                 pipe_enq__RDY,
    output logic [31:0]          msg_count,
    output logic                 busy
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    // Holding registers. Only the valid flags are reset; the data is
    // qualified by its flag and never needs a defined reset value.
    logic [N-1:0]     hold_v;
    logic [WIDTH-1:0] hold_d [N];
    logic [IDX_W-1:0] last;
    logic [31:0]      count;

    logic [IDX_W-1:0] sel;
    logic             any;
    logic [N-1:0]     drain;

    // Round-robin search starting one past the last grant. The modulo form
    // keeps the rotation correct for requester counts that are not a power
    // of two. With nothing valid, sel stays 0.
    always_comb begin
        int   idx;
        logic found;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && hold_v[idx]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign any           = |hold_v;
    assign busy          = any;
    assign pipe_enq__ENA = any & pipe_enq__RDY;
    assign pipe_enq_v    = hold_d[sel];
    assign msg_count     = count;

    // A slot accepts a new message when empty, or when it is the slot being
    // drained this cycle, which lets a single requester stream at full rate.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            drain[i]        = pipe_enq__ENA && (sel == IDX_W'(i));
            req_enq__RDY[i] = !hold_v[i] || (any && (sel == IDX_W'(i)) && pipe_enq__RDY);
        end
    end

    // Control state: valid flags, grant pointer, forwarded-message counter.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hold_v <= '0;
            last   <= IDX_W'(N - 1);
            count  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                hold_v[i] <= req_enq__ENA[i] | (hold_v[i] & ~drain[i]);
            end
            if (pipe_enq__ENA) begin
                last  <= sel;
                count <= count + 32'd1;
            end
        end
    end

    // Message capture.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (req_enq__ENA[i]) begin
                hold_d[i] <= req_enq_v[i*WIDTH +: WIDTH];
            end
        end
    end

    // Enqueueing into a slot that is not ready would overwrite a held message.
    a_no_enq_when_not_ready: assert property (
        @(posedge CLK) disable iff (!nRST)
        (req_enq__ENA & ~req_enq__RDY) == '0
    );

endmodule

// File: tb/tb_pipe_in_arbiter.sv
module tb_pipe_in_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 144;

    logic                CLK;
    logic                nRST;
    logic [N-1:0]        req_ena;
    logic [N*WIDTH-1:0]  req_v;
    logic [N-1:0]        req_rdy;
    logic                pipe_ena;
    logic [WIDTH-1:0]    pipe_v;
    logic                pipe_rdy;
    logic [31:0]         msg_count;
    logic                busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] exp_q [$];

    pipe_in_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .req_enq__ENA  (req_ena),
        .req_enq_v     (req_v),
        .req_enq__RDY  (req_rdy),
        .pipe_enq__ENA (pipe_ena),
        .pipe_enq_v    (pipe_v),
        .pipe_enq__RDY (pipe_rdy),
        .msg_count     (msg_count),
        .busy          (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: every pipe beat must match the next expected message.
    always @(negedge CLK) begin
        if (nRST && pipe_ena) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pipe_beat_unexpected: got %h, expected no beat", pipe_v);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (pipe_v !== e) begin
                    miscompares++;
                    $display("FAIL pipe_beat_data: got %h, expected %h", pipe_v, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        req_ena = '0;
        nRST    = 1'b0;
        tick();
        nRST    = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] val);
        req_ena[i] = 1'b1;
        req_v[i*WIDTH +: WIDTH] = val;
    endtask

    initial begin
        nRST     = 1'b0;
        req_ena  = '0;
        req_v    = '0;
        pipe_rdy = 1'b1;
        tick();
        do_reset();

        // Reset state, idle.
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_pipe_ena",  32'(pipe_ena),  32'd0);
        check("reset_rdy",       32'(req_rdy),   32'hF);
        check("reset_msg_count", msg_count,      32'd0);

        // Single message from requester 2, one-cycle latency.
        set_req(2, 144'hA5);
        exp_q.push_back(144'hA5);
        tick();
        req_ena = '0;
        check("single_pipe_ena", 32'(pipe_ena), 32'd1);
        tick();
        check("single_msg_count", msg_count,   32'd1);
        check("single_busy",      32'(busy),   32'd0);

        // All four at once: grants 0,1,2,3.
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_req(i, 144'h100 + 144'(i));
            exp_q.push_back(144'h100 + 144'(i));
        end
        tick();
        req_ena = '0;
        for (int c = 0; c < N; c++) begin
            check("all4_pipe_ena", 32'(pipe_ena), 32'd1);
            tick();
        end
        check("all4_msg_count", msg_count, 32'd4);
        check("all4_busy",      32'(busy), 32'd0);

        // Stall with requesters 1 and 3 holding.
        do_reset();
        pipe_rdy = 1'b0;
        set_req(1, 144'hB1);
        set_req(3, 144'hB3);
        exp_q.push_back(144'hB1);
        exp_q.push_back(144'hB3);
        tick();
        req_ena = '0;
        for (int c = 0; c < 5; c++) begin
            check("stall_pipe_ena", 32'(pipe_ena), 32'd0);
            check("stall_rdy",      32'(req_rdy),  32'h5);
            tick();
        end
        check("stall_msg_count", msg_count, 32'd0);
        pipe_rdy = 1'b1;
        tick();
        tick();
        check("stall_release_count", msg_count, 32'd2);

        // Requester 0 streams 1..8 back-to-back.
        do_reset();
        for (int v = 1; v <= 8; v++) begin
            check("stream_rdy0", 32'(req_rdy[0]), 32'd1);
            if (v > 1) check("stream_pipe_ena", 32'(pipe_ena), 32'd1);
            set_req(0, 144'(v));
            exp_q.push_back(144'(v));
            tick();
        end
        req_ena = '0;
        check("stream_last_ena", 32'(pipe_ena), 32'd1);
        tick();
        check("stream_msg_count", msg_count, 32'd8);

        // Reset while three slots are valid discards them.
        do_reset();
        pipe_rdy = 1'b0;
        set_req(0, 144'hD0);
        set_req(1, 144'hD1);
        set_req(2, 144'hD2);
        tick();
        req_ena = '0;
        check("midreset_busy_before", 32'(busy), 32'd1);
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        check("midreset_busy",      32'(busy),  32'd0);
        check("midreset_msg_count", msg_count,  32'd0);
        pipe_rdy = 1'b1;
        tick();
        check("midreset_pipe_ena", 32'(pipe_ena), 32'd0);
        tick();
        tick();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
